// File: rtl/comb_chk_pkg.sv
// Shared types and constants for comb_vector_checker: FSM states and the fixed (A,B)
// vector table.
package comb_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } chk_state_e;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned ERR_W   = 3;

    // Vector k is (VEC_A[k], VEC_B[k]): (0,1), (0,0), (1,0), (1,1)
    localparam logic [NUM_VEC-1:0] VEC_A = 4'b1100;
    localparam logic [NUM_VEC-1:0] VEC_B = 4'b1001;

endpackage

// File: rtl/settle_timer.sv
// Settle counter: counts 0..SETTLE_CYC-1 while enabled and flags the last count with tc.
module settle_timer
    import comb_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);

    logic [3:0] cnt_q, cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/comb_vector_checker.sv
// Drives the four (A,B) vectors into a 2-input combinational DUT and checks C against
// EXP_TT. Optional mismatch_mask output when CHK_MISMATCH_MASK_EN is defined.
module comb_vector_checker
    import comb_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [3:0]  EXP_TT     = 4'b1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             c_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail
`ifdef CHK_MISMATCH_MASK_EN
    ,
    output logic [3:0]       mismatch_mask
`endif
);

    chk_state_e       state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       ff_q, ff_d;
    logic             pass_q, pass_d;
    logic             timer_clr, timer_en, timer_tc;
    logic             cur_a, cur_b;
`ifdef CHK_MISMATCH_MASK_EN
    logic [3:0]       mask_q, mask_d;
    assign mismatch_mask = mask_q;
`endif

    assign cur_a      = VEC_A[vec_q];
    assign cur_b      = VEC_B[vec_q];
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign pass       = pass_q;

    settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clr),
        .en   (timer_en),
        .tc   (timer_tc)
    );

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        err_d     = err_q;
        ff_d      = ff_q;
        pass_d    = pass_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        a_out     = 1'b0;
        b_out     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef CHK_MISMATCH_MASK_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    vec_d     = '0;
                    err_d     = '0;
                    ff_d      = '0;
                    pass_d    = 1'b0;
                    timer_clr = 1'b1;
`ifdef CHK_MISMATCH_MASK_EN
                    mask_d    = '0;
`endif
                end
            end
            StRun: begin
                busy     = 1'b1;
                a_out    = cur_a;
                b_out    = cur_b;
                timer_en = 1'b1;
                // c_in is only looked at on the compare edge; glitches elsewhere are ignored
                if (timer_tc) begin
                    if (c_in != EXP_TT[{cur_a, cur_b}]) begin
                        err_d = err_q + 3'd1;
                        if (err_q == '0) begin
                            ff_d = vec_q;
                        end
`ifdef CHK_MISMATCH_MASK_EN
                        mask_d[vec_q] = 1'b1;
`endif
                    end
                    vec_d = vec_q + 2'd1;
                    if (vec_q == 2'(NUM_VEC - 1)) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
`ifdef CHK_MISMATCH_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
`ifdef CHK_MISMATCH_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_comb_vector_checker.sv
// Randomized self-checking bench for comb_vector_checker: three instances with different
// SETTLE_CYC/EXP_TT, each fed by a bench-modelled 2-input DUT.
module tb_comb_vector_checker;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, start, c_in, glitch, a_o, b_o, busy_o, done_o, pass_o;
    logic [2:0]    err_o  [NI];
    logic [1:0]    ff_o   [NI];
    logic [3:0]    mask_o [NI];
    logic [3:0]    fn     [NI];

    int total = 0;
    int bad   = 0;

    // Per-instance configuration, as given to the instances below
    function automatic int s_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] e_of(input int i);
        case (i)
            0:       return 4'b1000;
            1:       return 4'b1000;
            default: return 4'b1111;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_cin
        assign c_in[g] = fn[g][{a_o[g], b_o[g]}] ^ glitch[g];
`ifndef CHK_MISMATCH_MASK_EN
        assign mask_o[g] = '0;
`endif
    end

    comb_vector_checker #(.SETTLE_CYC(2), .EXP_TT(4'b1000)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .c_in(c_in[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_cnt(err_o[0]), .first_fail(ff_o[0])
`ifdef CHK_MISMATCH_MASK_EN
        , .mismatch_mask(mask_o[0])
`endif
    );

    comb_vector_checker #(.SETTLE_CYC(1), .EXP_TT(4'b1000)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .c_in(c_in[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_cnt(err_o[1]), .first_fail(ff_o[1])
`ifdef CHK_MISMATCH_MASK_EN
        , .mismatch_mask(mask_o[1])
`endif
    );

    comb_vector_checker #(.SETTLE_CYC(3), .EXP_TT(4'b1111)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .c_in(c_in[2]),
        .a_out(a_o[2]), .b_out(b_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .err_cnt(err_o[2]), .first_fail(ff_o[2])
`ifdef CHK_MISMATCH_MASK_EN
        , .mismatch_mask(mask_o[2])
`endif
    );

    // Reference: vector k as {A,B}, and the checker's verdict from the truth tables alone
    logic [1:0] vec_ab [4];
    initial vec_ab = '{2'b01, 2'b00, 2'b10, 2'b11};

    function automatic void model(input logic [3:0] dfn, input logic [3:0] exp_tt,
                                  output int e, output int ff, output logic [3:0] m);
        e  = 0;
        ff = 0;
        m  = '0;
        for (int k = 3; k >= 0; k--) begin
            if (dfn[vec_ab[k]] != exp_tt[vec_ab[k]]) begin
                e++;
                ff = k;
                m[k] = 1'b1;
            end
        end
    endfunction

    // Trace of one run: cycle j is sampled at the falling edge after start edge E0 + j
    logic [3:0] obs [16];   // {a,b,busy,done}
    logic [2:0] fin_err;
    logic [1:0] fin_ff;
    logic       fin_pass;
    logic [3:0] fin_mask;
    logic       post_pass;

    task automatic run_seq(input int i, input logic [3:0] dfn, input bit do_glitch,
                           input bit spam);
        int s;
        s = s_of(i);
        fn[i] = dfn;
        @(negedge clk);
        start[i] = 1'b1;
        for (int j = 0; j <= 4 * s + 2; j++) begin
            @(negedge clk);
            obs[j] = {a_o[i], b_o[i], busy_o[i], done_o[i]};
            if (j == 4 * s) begin
                fin_err  = err_o[i];
                fin_ff   = ff_o[i];
                fin_pass = pass_o[i];
                fin_mask = mask_o[i];
            end
            post_pass = pass_o[i];
            if (spam && j < 4 * s)       start[i] = 1'($urandom_range(0, 1));
            else if (spam && j == 4 * s) start[i] = 1'b1;
            else                         start[i] = 1'b0;
            glitch[i] = (do_glitch && j < 4 * s && ((j + 1) % s) != 0) ?
                        1'($urandom_range(0, 1)) : 1'b0;
        end
        start[i]  = 1'b0;
        glitch[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            total++;
            if ({a_o[i], b_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], ff_o[i]} !== 9'd0) begin
                bad++;
                $display("FAIL reset_outputs inst%0d: got %b want 0", i,
                         {a_o[i], b_o[i], busy_o[i], done_o[i], pass_o[i], err_o[i], ff_o[i]});
            end
        end
        rst = '0;
        @(negedge clk);
    endtask

    task automatic test_and_basic();
        run_seq(0, 4'b1000, 1'b0, 1'b0);
        for (int j = 0; j <= 10; j++) begin
            logic [3:0] want;
            want = (j < 8) ? {vec_ab[j / 2], 2'b10} : (j == 8) ? 4'b0001 : 4'b0000;
            total++;
            if (obs[j] !== want) begin
                bad++;
                $display("FAIL and_trace cycle%0d: got %b want %b", j, obs[j], want);
            end
        end
        total++;
        if ({fin_pass, fin_err} !== 4'b1000) begin
            bad++;
            $display("FAIL and_result: got pass/err %b want 1000", {fin_pass, fin_err});
        end
    endtask

    task automatic test_or_dut();
        run_seq(0, 4'b1110, 1'b0, 1'b0);
        total++;
        if ({fin_pass, fin_err, fin_ff} !== {1'b0, 3'd2, 2'd0}) begin
            bad++;
            $display("FAIL or_result: got pass/err/ff %b want 0_010_00", {fin_pass, fin_err, fin_ff});
        end
`ifdef CHK_MISMATCH_MASK_EN
        total++;
        if (fin_mask !== 4'b0101) begin
            bad++;
            $display("FAIL or_mask: got %b want 0101", fin_mask);
        end
`endif
    endtask

    task automatic test_stuck0();
        run_seq(2, 4'b0000, 1'b0, 1'b0);
        total++;
        if ({obs[12][0], fin_pass, fin_err, fin_ff} !== {1'b1, 1'b0, 3'd4, 2'd0}) begin
            bad++;
            $display("FAIL stuck0_result: got done/pass/err/ff %b want 1_0_100_00",
                     {obs[12][0], fin_pass, fin_err, fin_ff});
        end
    endtask

    task automatic test_settle1();
        run_seq(1, 4'b1000, 1'b0, 1'b0);
        for (int j = 0; j <= 6; j++) begin
            total++;
            if (obs[j][0] !== (j == 4)) begin
                bad++;
                $display("FAIL settle1_done cycle%0d: got %b want %b", j, obs[j][0], j == 4);
            end
        end
        total++;
        if (obs[2][3:2] !== 2'b10 || fin_pass !== 1'b1) begin
            bad++;
            $display("FAIL settle1_vec2_pass: got ab=%b pass=%b want ab=10 pass=1",
                     obs[2][3:2], fin_pass);
        end
    endtask

    task automatic test_glitch();
        run_seq(2, 4'b1111, 1'b1, 1'b0);
        total++;
        if ({fin_pass, fin_err} !== 4'b1000) begin
            bad++;
            $display("FAIL glitch_s3: got pass/err %b want 1000", {fin_pass, fin_err});
        end
        run_seq(0, 4'b1000, 1'b1, 1'b0);
        total++;
        if ({fin_pass, fin_err} !== 4'b1000) begin
            bad++;
            $display("FAIL glitch_s2: got pass/err %b want 1000", {fin_pass, fin_err});
        end
    endtask

    task automatic test_back_to_back();
        run_seq(0, 4'b1000, 1'b0, 1'b1);
        for (int j = 0; j <= 10; j++) begin
            logic [3:0] want;
            want = (j < 8) ? {vec_ab[j / 2], 2'b10} : (j == 8) ? 4'b0001 : 4'b0000;
            total++;
            if (obs[j] !== want) begin
                bad++;
                $display("FAIL restart_ignored cycle%0d: got %b want %b", j, obs[j], want);
            end
        end
    endtask

    task automatic test_rst_mid();
        int saw_done;
        fn[0] = 4'b1110;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({a_o[0], b_o[0], busy_o[0]} !== 3'b101) begin
            bad++;
            $display("FAIL rst_mid_vec2: got ab/busy %b want 101", {a_o[0], b_o[0], busy_o[0]});
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        total++;
        if ({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], err_o[0], ff_o[0]} !== 9'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %b want 0",
                     {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], err_o[0], ff_o[0]});
        end
        saw_done = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) saw_done++;
        end
        total++;
        if (saw_done != 0) begin
            bad++;
            $display("FAIL rst_mid_no_done: got %0d active cycles want 0", saw_done);
        end
        run_seq(0, 4'b1000, 1'b0, 1'b0);
        total++;
        if ({obs[8][0], fin_pass, fin_err} !== 5'b11000) begin
            bad++;
            $display("FAIL rst_mid_rerun: got done/pass/err %b want 11000",
                     {obs[8][0], fin_pass, fin_err});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int         i, s, e, ff, nbad;
            logic [3:0] dfn, m;
            bit         gl, sp;
            i   = $urandom_range(0, NI - 1);
            s   = s_of(i);
            dfn = 4'($urandom);
            gl  = 1'($urandom_range(0, 1));
            sp  = 1'($urandom_range(0, 1));
            model(dfn, e_of(i), e, ff, m);
            run_seq(i, dfn, gl, sp);
            nbad = 0;
            for (int j = 0; j <= 4 * s + 2; j++) begin
                logic [3:0] want;
                want = (j < 4 * s) ? {vec_ab[j / s], 2'b10} :
                       (j == 4 * s) ? 4'b0001 : 4'b0000;
                if (obs[j] !== want) nbad++;
            end
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL rand%0d_trace inst%0d fn=%b: got %0d bad cycles want 0",
                         n, i, dfn, nbad);
            end
            total++;
            if (fin_err !== 3'(e) || fin_pass !== (e == 0) || post_pass !== (e == 0) ||
                (e != 0 && fin_ff !== 2'(ff))) begin
                bad++;
                $display("FAIL rand%0d_result inst%0d fn=%b: got err=%0d ff=%0d pass=%b/%b want err=%0d ff=%0d pass=%b",
                         n, i, dfn, fin_err, fin_ff, fin_pass, post_pass, e, ff, e == 0);
            end
`ifdef CHK_MISMATCH_MASK_EN
            total++;
            if (fin_mask !== m) begin
                bad++;
                $display("FAIL rand%0d_mask: got %b want %b", n, fin_mask, m);
            end
`endif
        end
    endtask

    initial begin
        start  = '0;
        glitch = '0;
        rst    = '1;
        for (int i = 0; i < NI; i++) fn[i] = 4'b0000;
        test_reset();
        test_and_basic();
        test_or_dut();
        test_stuck0();
        test_settle1();
        test_glitch();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
